wb_team_interconnect: RTL
=========================

WB_TEAM_INTERCONNECT -- requirements
Module: wb_team_interconnect

Interface
REQ-001 SHALL have parameter NUM_TEAMS, default 1, number of team design targets (legal range 1..14).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum target wait in cycles (legal range 2..255).
REQ-003 SHALL have parameter BASE_ADDR, default 12'h300, required value of wbs_adr_i[31:20].
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 wb_clk_i  in  1  system clock, all state on rising edge.
REQ-006 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-007 wbs_cyc_i, wbs_stb_i  in  1 each  Wishbone master cycle and strobe.
REQ-008 wbs_adr_i  in  32  master address.
REQ-009 wbs_ack_o  out  1  acknowledge to master.
REQ-010 wbs_dat_o  out  32  read data to master.
REQ-011 adr_truncated  out  32  {16'h0, wbs_adr_i[15:0]}, combinational.
REQ-012 designs_stb  out  NUM_TEAMS  per-team strobe; bit n-1 is team n.
REQ-013 gpio_control_stb, la_control_stb  out  1 each  control-block strobes.
REQ-014 designs_dat_o  in  32*NUM_TEAMS  team read data; team n occupies bits [32n-1:32(n-1)].
REQ-015 designs_ack_o  in  NUM_TEAMS  per-team acks.
REQ-016 gpio_control_dat_o, la_control_dat_o  in  32 each; gpio_control_ack_o, la_control_ack_o  in  1 each.
REQ-017 err_o  out  1  one-cycle pulse on decode error or timeout.
REQ-018 timeout_count  out  8  saturating count of timeouts since reset.

Function
REQ-019 Slot SHALL be wbs_adr_i[19:16]: 0 = gpio control, 15 = la control, 1..NUM_TEAMS = team n; all else invalid.
REQ-020 Address SHALL be valid only if wbs_adr_i[31:20] == BASE_ADDR and slot is mapped.
REQ-021 FSM states SHALL be IDLE, ACTIVE, RESP.
REQ-022 IDLE: cyc&stb with valid address -> latch slot, go ACTIVE; invalid -> latch error data 32'hBADA_DD00 | slot, pulse err_o, go RESP.
REQ-023 ACTIVE: exactly the latched slot's strobe SHALL equal wbs_cyc_i & wbs_stb_i; all other target strobes 0.
REQ-024 ACTIVE: selected target ack -> latch its dat_o, go RESP; target strobe SHALL be 0 from the RESP cycle on.
REQ-025 ACTIVE: wait counter SHALL start at 0 on entry, increment each cycle; when it equals TIMEOUT_CYCLES-1 without ack -> latch 32'hDEAD_0000 | slot, pulse err_o, increment timeout_count (saturate at 255), go RESP.
REQ-026 Ack and timeout in the same cycle: ack SHALL win; no error, no count.
REQ-027 ACTIVE: wbs_cyc_i low -> return to IDLE, no ack, no err_o, strobes 0 next cycle (master abort).
REQ-028 RESP: wbs_ack_o SHALL be 1 for exactly one cycle with latched data; then IDLE.
REQ-029 Latency: target ack at cycle k -> wbs_ack_o at cycle k+1; decode error: request at cycle k -> wbs_ack_o at k+1.
REQ-030 wbs_dat_o SHALL be 0 whenever wbs_ack_o is 0.
REQ-031 Acks from non-selected targets SHALL be ignored in all states.
REQ-032 A new request SHALL not be accepted in RESP; earliest acceptance is the cycle after RESP.

Reset
REQ-033 On wb_rst_i high, immediately: state IDLE, all strobes 0, wbs_ack_o 0, wbs_dat_o 0, err_o 0, timeout_count 0, wait counter 0, latched slot/data 0.
REQ-034 Reset mid-transaction SHALL abort it with no ack issued after reset release.

Verification
REQ-035 NUM_TEAMS=3: read adr 32'h3002_0010, team 2 acks after 3 cycles with 32'h1234_5678 -> designs_stb=3'b010 during wait, adr_truncated=32'h0000_0010, wbs_ack_o one cycle later with 32'h1234_5678.
REQ-036 adr 32'h3005_0000 with NUM_TEAMS=3 -> no strobe, wbs_ack_o next cycle, wbs_dat_o=32'hBADA_DD05, err_o pulse.
REQ-037 TIMEOUT_CYCLES=8, adr 32'h300F_0000, la never acks -> la_control_stb high 8 cycles, ack with 32'hDEAD_000F, timeout_count=1.
REQ-038 Team 1 ack coincident with final timeout cycle -> normal data returned, err_o 0, timeout_count unchanged.
REQ-039 Drop wbs_cyc_i in ACTIVE, then assert wb_rst_i mid second transaction -> no ack either time, all outputs 0, next request served normally.

Source files
------------

// File: rtl/wb_team_interconnect.sv
// Purpose: Wishbone slave-side decoder routing one master to gpio/la control blocks and up to 14 team designs.
// Latency: target ack at cycle k -> wbs_ack_o at k+1; decode error or timeout answered one cycle after detection.
// Backpressure: one transaction in flight; a waiting target holds the master until ack, timeout or master abort.
module wb_team_interconnect #(
    parameter int          NUM_TEAMS      = 1,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [11:0] BASE_ADDR      = 12'h300
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic [31:0]               wbs_adr_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [31:0]               adr_truncated,
    output logic [NUM_TEAMS-1:0]      designs_stb,
    output logic                      gpio_control_stb,
    output logic                      la_control_stb,
    input  logic [32*NUM_TEAMS-1:0]   designs_dat_o,
    input  logic [NUM_TEAMS-1:0]      designs_ack_o,
    input  logic [31:0]               gpio_control_dat_o,
    input  logic [31:0]               la_control_dat_o,
    input  logic                      gpio_control_ack_o,
    input  logic                      la_control_ack_o,
    output logic                      err_o,
    output logic [7:0]                timeout_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LP_SLOT_GPIO = 4'd0;
    localparam logic [3:0] LP_SLOT_LA   = 4'd15;
    localparam logic [3:0] LP_MAX_TEAM  = 4'(NUM_TEAMS);
    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_slot;
    logic [31:0] r_dat;
    logic        r_is_err;
    logic [7:0]  r_wait;
    logic [7:0]  r_timeout_count;

    logic        w_req;
    logic [3:0]  w_slot;
    logic        w_slot_mapped;
    logic        w_adr_valid;
    logic        w_sel_ack;
    logic [31:0] w_sel_dat;
    logic        w_accept;
    logic        w_dec_err;
    logic        w_tgt_ack;
    logic        w_tmo;

    assign w_req         = wbs_cyc_i & wbs_stb_i;
    assign w_slot        = wbs_adr_i[19:16];
    assign w_slot_mapped = (w_slot == LP_SLOT_GPIO) || (w_slot == LP_SLOT_LA) ||
                           ((w_slot >= 4'd1) && (w_slot <= LP_MAX_TEAM));
    assign w_adr_valid   = (wbs_adr_i[31:20] == BASE_ADDR) && w_slot_mapped;
    assign adr_truncated = {16'h0000, wbs_adr_i[15:0]};

    // Ack/data of the latched target only; every other target's ack is ignored.
    always_comb begin
        w_sel_ack = 1'b0;
        w_sel_dat = 32'h0;
        if (r_slot == LP_SLOT_GPIO) begin
            w_sel_ack = gpio_control_ack_o;
            w_sel_dat = gpio_control_dat_o;
        end else if (r_slot == LP_SLOT_LA) begin
            w_sel_ack = la_control_ack_o;
            w_sel_dat = la_control_dat_o;
        end else begin
            for (int t = 0; t < NUM_TEAMS; t++) begin
                if (r_slot == 4'(t + 1)) begin
                    w_sel_ack = designs_ack_o[t];
                    w_sel_dat = designs_dat_o[32*t +: 32];
                end
            end
        end
    end

    // Target strobes follow the master strobe only while waiting on the latched target.
    always_comb begin
        designs_stb      = '0;
        gpio_control_stb = 1'b0;
        la_control_stb   = 1'b0;
        if ((r_state == ST_ACTIVE) && w_req) begin
            if (r_slot == LP_SLOT_GPIO) begin
                gpio_control_stb = 1'b1;
            end else if (r_slot == LP_SLOT_LA) begin
                la_control_stb = 1'b1;
            end else begin
                for (int t = 0; t < NUM_TEAMS; t++) begin
                    if (r_slot == 4'(t + 1)) begin
                        designs_stb[t] = 1'b1;
                    end
                end
            end
        end
    end

    // Event decode; a master abort takes priority, and ack beats a coincident timeout.
    always_comb begin
        w_accept  = (r_state == ST_IDLE) && w_req && w_adr_valid;
        w_dec_err = (r_state == ST_IDLE) && w_req && !w_adr_valid;
        w_tgt_ack = (r_state == ST_ACTIVE) && wbs_cyc_i && w_sel_ack;
        w_tmo     = (r_state == ST_ACTIVE) && wbs_cyc_i && !w_sel_ack &&
                    (r_wait == LP_WAIT_LAST);
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_dec_err) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_ACTIVE: begin
                if (!wbs_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tgt_ack || w_tmo) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched slot, response data/error flag, wait counter and saturating timeout count.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_slot          <= 4'd0;
            r_dat           <= 32'h0;
            r_is_err        <= 1'b0;
            r_wait          <= 8'd0;
            r_timeout_count <= 8'd0;
        end else begin
            if ((r_state == ST_IDLE) && w_req) begin
                r_slot <= w_slot;
            end
            if (r_state == ST_ACTIVE) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
            if (w_dec_err) begin
                r_dat    <= 32'hBADA_DD00 | {28'h0, w_slot};
                r_is_err <= 1'b1;
            end else if (w_tgt_ack) begin
                r_dat    <= w_sel_dat;
                r_is_err <= 1'b0;
            end else if (w_tmo) begin
                r_dat    <= 32'hDEAD_0000 | {28'h0, r_slot};
                r_is_err <= 1'b1;
            end
            if (w_tmo && (r_timeout_count != 8'hFF)) begin
                r_timeout_count <= r_timeout_count + 8'd1;
            end
        end
    end

    assign wbs_ack_o     = (r_state == ST_RESP);
    assign wbs_dat_o     = wbs_ack_o ? r_dat : 32'h0;
    assign err_o         = wbs_ack_o & r_is_err;
    assign timeout_count = r_timeout_count;

endmodule
